// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared state type, frame sizes and status-word layout for the touch panel SPI master
package touch_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} touchState_e;

  localparam int CMD_BITS   = 8;
  localparam int READ_BITS  = 16;
  localparam int TOTAL_BITS = CMD_BITS + READ_BITS;

  localparam int BUSY_BIT   = 15;
  localparam int PEN_BIT    = 14;
  localparam int RESULT_MSB = 11;

  localparam int RX_HI = 14;
  localparam int RX_LO = 3;
endpackage

// File: rtl/touch_sck_div.sv
// rtl/touch_sck_div.sv - sck phase divider; one-cycle phaseTick at the end of each CLK_DIV-cycle phase
module touch_sck_div
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic phaseTick
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] count;

  assign phaseTick = en && !clr && (count == DIV_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr || phaseTick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end
endmodule

// File: rtl/touch_spi.sv
// rtl/touch_spi.sv - memory-mapped SPI master for an XPT2046-class touch controller
// Optional pen-down input and status bit enabled by defining TOUCH_PENIRQ_EN.
module touch_spi
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic [CMD_BITS-1:0] in,
`ifdef TOUCH_PENIRQ_EN
  input  logic                penirq_n,
`endif
  output logic [15:0]         out,
  output logic                mosi,
  input  logic                miso,
  output logic                sck
);
  localparam logic [4:0] CMD_CNT  = 5'(CMD_BITS);
  localparam logic [4:0] LAST_BIT = 5'(TOTAL_BITS - 1);

  touchState_e           state;
  logic [4:0]            bitCnt;
  logic [CMD_BITS-1:0]   txShift;
  logic [READ_BITS-1:0]  rxShift;
  logic [RESULT_MSB:0]   result;
  logic                  busy;
  logic                  pen;
  logic                  phaseTick;

  touch_sck_div #(.CLK_DIV(CLK_DIV)) uDiv (
    .clk      (clk),
    .rstn     (rstn),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .phaseTick(phaseTick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      bitCnt  <= '0;
      txShift <= '0;
      rxShift <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            txShift <= in;
            rxShift <= '0;
            bitCnt  <= '0;
            mosi    <= in[CMD_BITS-1];
            busy    <= 1'b1;
            state   <= LOW;
          end
        end
        LOW: begin
          if (phaseTick) begin
            sck   <= 1'b1;
            state <= HIGH;
            // Reply bits only follow the command; earlier miso is don't-care.
            if (bitCnt >= CMD_CNT) rxShift <= {rxShift[READ_BITS-2:0], miso};
          end
        end
        HIGH: begin
          if (phaseTick) begin
            sck <= 1'b0;
            if (bitCnt == LAST_BIT) begin
              state  <= IDLE;
              busy   <= 1'b0;
              mosi   <= 1'b0;
              bitCnt <= '0;
              result <= rxShift[RX_HI:RX_LO];
            end else begin
              state   <= LOW;
              bitCnt  <= bitCnt + 5'd1;
              txShift <= {txShift[CMD_BITS-2:0], 1'b0};
              mosi    <= txShift[CMD_BITS-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TOUCH_PENIRQ_EN
  logic [1:0] penSync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) penSync <= 2'b11;
    else       penSync <= {penSync[0], penirq_n};
  end

  assign pen = ~penSync[1];
`else
  assign pen = 1'b0;
`endif

  always_comb begin
    out               = '0;
    out[BUSY_BIT]     = busy;
    out[PEN_BIT]      = pen;
    out[RESULT_MSB:0] = result;
  end
endmodule

// File: tb/tb_touch_spi.sv
// tb/tb_touch_spi.sv - randomized self-checking bench for touch_spi against a frame-level panel model
module tb_touch_spi;
  localparam int DIV    = 2;
  localparam int FRAME  = 48 * DIV;
  localparam int BUDGET = FRAME + 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load = 1'b0;
  logic        miso = 1'b0;
  logic        penirq_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [15:0] dout;
  logic        mosi;
  logic        sck;

  logic [15:0] panelWord = 16'h0000;
  logic [23:0] mosiBits = 24'h0;
  logic [11:0] expResult = 12'h000;
  int          pulses = 0;
  int          total = 0;
  int          bad = 0;

  touch_spi #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .load    (load),
    .in      (din),
`ifdef TOUCH_PENIRQ_EN
    .penirq_n(penirq_n),
`endif
    .out     (dout),
    .mosi    (mosi),
    .miso    (miso),
    .sck     (sck)
  );

  always #5 clk = ~clk;

  // Panel: records the command on rising edges, then serves panelWord MSB first.
  always @(posedge sck) begin
    mosiBits = {mosiBits[22:0], mosi};
    pulses   = pulses + 1;
    if (pulses >= 8 && pulses < 24) miso = panelWord[15 - (pulses - 8)];
    else                            miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives load immediately and returns at the negedge where busy is first 0.
  task automatic runTxn(input logic [7:0] cmd, input logic [15:0] word, input int hold,
                        input int injectAt, input bit lateLoad);
    int n;
    int holdErr;
    n = 0;
    holdErr = 0;
    panelWord = word;
    pulses = 0;
    mosiBits = 24'h0;
    load = 1'b1;
    din = cmd;
    @(negedge clk);
    chk("startBusy", dout[15], 1'b1);
    chk("startMosi", mosi, cmd[7]);
    chk("startSck", sck, 1'b0);
    while (dout[15] === 1'b1 && n < BUDGET) begin
      n++;
      load = (n < hold);
      if (n == injectAt) begin
        load = 1'b1;
        din = 8'hD0;
      end
      if (lateLoad && n == FRAME) load = 1'b1;
      if (dout[11:0] !== expResult || dout[13:12] !== 2'b00) holdErr++;
      @(negedge clk);
    end
    load = 1'b0;
    expResult = word[14:3];
    chk("busyCycles", n, FRAME);
    chk("result", dout, {4'h0, expResult});
    chk("endSck", sck, 1'b0);
    chk("sckPulses", pulses, 24);
    chk("mosiSeq", mosiBits, {cmd, 16'h0000});
    chk("holdPrev", holdErr, 0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    int rstErr;
    int k;
    logic [7:0]  cmd;
    logic [15:0] word;

    rstErr = 0;
    idle(3);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (dout !== 16'h0000 || sck !== 1'b0 || mosi !== 1'b0) rstErr++;
      @(negedge clk);
    end
    chk("resetIdle", rstErr, 0);
    chk("resetOut", dout, 16'h0000);

    runTxn(8'h90, 16'h55E0, 1, 0, 1'b0);
    idle(2);

    runTxn(8'h90, 16'h55E0, 1, 40, 1'b0);
    idle(4);
    chk("injectNoRestart", pulses, 24);

    runTxn(8'h93, 16'h7FF8, 3, 0, 1'b1);
    idle(5);
    chk("lateLoadBusy", dout[15], 1'b0);
    chk("lateLoadPulses", pulses, 24);

    runTxn(8'hA5, 16'h7FF8, 1, 0, 1'b0);
    runTxn(8'hD0, 16'h0008, 1, 0, 1'b0);
    chk("backToBack", dout[11:0], 12'h001);

    for (int i = 0; i < 6; i++) begin
      cmd  = 8'($urandom);
      word = 16'($urandom);
      runTxn(cmd, word, int'($urandom_range(1, 3)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, FRAME - 2)) : 0,
             1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    panelWord = 16'($urandom);
    pulses = 0;
    load = 1'b1;
    din = 8'($urandom);
    @(negedge clk);
    load = 1'b0;
    k = 0;
    while (pulses < 10 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    chk("reachPulse10", pulses, 10);
    rstn = 1'b0;
    #1;
    chk("abortOut", dout, 16'h0000);
    chk("abortSck", sck, 1'b0);
    chk("abortMosi", mosi, 1'b0);
    expResult = 12'h000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    runTxn(8'($urandom), 16'($urandom), 1, 0, 1'b0);

`ifdef TOUCH_PENIRQ_EN
    idle(2);
    penirq_n = 1'b0;
    @(negedge clk);
    chk("penFall1", dout[14], 1'b0);
    @(negedge clk);
    chk("penFall2", dout[14], 1'b1);
    penirq_n = 1'b1;
    @(negedge clk);
    chk("penRise1", dout[14], 1'b1);
    @(negedge clk);
    chk("penRise2", dout[14], 1'b0);
    load = 1'b1;
    din = 8'hD0;
    panelWord = 16'h1234;
    pulses = 0;
    @(negedge clk);
    load = 1'b0;
    idle(5);
    penirq_n = 1'b0;
    @(negedge clk);
    chk("penBusy1", dout[14], 1'b0);
    @(negedge clk);
    chk("penBusy2", dout[14], 1'b1);
    chk("penBusyFlag", dout[15], 1'b1);
    k = 0;
    while (dout[15] === 1'b1 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    expResult = panelWord[14:3];
    chk("penResult", dout, {4'h4, expResult});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
